// File: rtl/conv1_pkg.sv
// Shared conv1 geometry and control state encoding, used by the output
// writer and the read addresser.
package conv1_pkg;

    localparam int unsigned IMG_W  = 24;
    localparam int unsigned IMG_H  = 24;
    localparam int unsigned DEPTH  = IMG_W * IMG_H;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned POS_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/conv1_pos_counter.sv
// Row/column/linear-address tracker for a row-major frame; the address is a
// running counter so no multiplier is needed.
module conv1_pos_counter
    import conv1_pkg::*;
#(
    parameter int unsigned COLS = conv1_pkg::IMG_W,
    parameter int unsigned ROWS = conv1_pkg::IMG_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    output logic [POS_W-1:0]  row,
    output logic [POS_W-1:0]  col,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    logic col_wrap_c;

    assign col_wrap_c = (col == POS_W'(COLS - 1));
    assign last_c     = col_wrap_c && (row == POS_W'(ROWS - 1));

    // Clear wins over step; column wraps into the next row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (clear) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (step) begin
            addr <= addr + ADDR_W'(1);
            if (col_wrap_c) begin
                col <= '0;
                row <= row + POS_W'(1);
            end else begin
                col <= col + POS_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv1_mem_write.sv
// Writes one conv1 frame of results into the conv1 output memory in
// row-major order, one write per accepted result with one cycle of latency.
module conv1_mem_write
    import conv1_pkg::*;
#(
    parameter int unsigned IMG_W  = conv1_pkg::IMG_W,
    parameter int unsigned IMG_H  = conv1_pkg::IMG_H,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [POS_W-1:0]  row,
    output logic [POS_W-1:0]  col,
    output logic              done,
    output logic              overrun
);

    state_t            state;
    state_t            state_next;
    logic              accept_c;
    logic              restart_c;
    logic              last_c;
    logic              step_c;
    logic [ADDR_W-1:0] addr;

    assign in_ready  = (state == WRITE) && enable;
    assign accept_c  = in_valid && in_ready;
    assign restart_c = start && (state != WRITE);
    // Final position is held in DONE rather than wrapping back to zero.
    assign step_c    = accept_c && !last_c;

    conv1_pos_counter #(
        .COLS (IMG_W),
        .ROWS (IMG_H)
    ) u_pos (
        .clk    (clk),
        .reset  (reset),
        .clear  (restart_c),
        .step   (step_c),
        .row    (row),
        .col    (col),
        .addr   (addr),
        .last_c (last_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WRITE;
            WRITE:   if (accept_c && last_c) state_next = DONE;
            DONE:    if (start) state_next = WRITE;
            default: state_next = IDLE;
        endcase
    end

    // Write port: registered copy of each accepted result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept_c;
            if (accept_c) begin
                wr_addr <= addr;
                wr_data <= in_data;
            end
        end
    end

    // done is sticky until restart; overrun only clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (restart_c) begin
                done <= 1'b0;
            end else if (accept_c && last_c) begin
                done <= 1'b1;
            end
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv1_mem_write.sv
// Scoreboard bench for conv1_mem_write: stimulus queues expected writes,
// a negedge monitor pops and compares every wr_en cycle.
module tb_conv1_mem_write;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 576;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          wr_en;
    logic [9:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [4:0]    row;
    logic [4:0]    col;
    logic          done;
    logic          overrun;

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    int unsigned   wr_cnt = 0;
    int unsigned   exp_addr = 0;
    int unsigned   snap;
    logic [9:0]    q_addr[$];
    logic [DW-1:0] q_data[$];

    conv1_mem_write dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .row      (row),
        .col      (col),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                wr_cnt++;
                if (q_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got wr_en=1 addr %0d expected no write at %0t",
                             wr_addr, $time);
                end else begin
                    chk("wr_addr", 32'(wr_addr), 32'(q_addr.pop_front()));
                    chk("wr_data", 32'(wr_data), 32'(q_data.pop_front()));
                end
            end
        end
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_addr = 0;
    endtask

    // Present one result; the bench's own model says it is accepted this edge.
    task automatic accept_one(input int unsigned d);
        in_valid = 1'b1;
        in_data  = DW'(d);
        @(posedge clk);
        q_addr.push_back(10'(exp_addr));
        q_data.push_back(DW'(d));
        exp_addr++;
        #1;
    endtask

    initial begin
        int unsigned n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_row", 32'(row), 0);
        chk("rst_col", 32'(col), 0);
        reset = 1'b0;
        settle();
        chk("idle_in_ready", 32'(in_ready), 0);

        // Frame 1: back-to-back, data = index
        do_start();
        chk("write_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == 23) begin
                chk("row_at_23", 32'(row), 0);
                chk("col_at_23", 32'(col), 23);
            end
            if (i == 24) begin
                chk("row_at_24", 32'(row), 1);
                chk("col_at_24", 32'(col), 0);
            end
            if (i == int'(DEPTH) - 1) chk("done_before_last", 32'(done), 0);
            accept_one(32'(i));
        end
        in_valid = 1'b0;
        chk("done_on_last_wr", 32'(done), 1);
        chk("last_wr_en", 32'(wr_en), 1);
        chk("last_wr_addr", 32'(wr_addr), 575);
        chk("f1_overrun", 32'(overrun), 0);
        settle();
        chk("done_in_ready", 32'(in_ready), 0);
        chk("f1_wr_count", wr_cnt, DEPTH);

        // in_valid while DONE: no write, overrun, position held
        snap = wr_cnt;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        settle();
        chk("done_no_write", wr_cnt, snap);
        chk("done_overrun", 32'(overrun), 1);
        chk("done_row_hold", 32'(row), 23);
        chk("done_col_hold", 32'(col), 23);
        chk("done_sticky", 32'(done), 1);

        // Restart, then abandon the frame with an asynchronous reset
        do_start();
        chk("restart_row", 32'(row), 0);
        chk("restart_col", 32'(col), 0);
        chk("restart_done", 32'(done), 0);
        chk("restart_overrun_kept", 32'(overrun), 1);
        for (int i = 0; i < 100; i++) accept_one(32'(2000 + i));
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_wr_en", 32'(wr_en), 0);
        chk("async_wr_addr", 32'(wr_addr), 0);
        chk("async_wr_data", 32'(wr_data), 0);
        chk("async_row", 32'(row), 0);
        chk("async_col", 32'(col), 0);
        chk("async_done", 32'(done), 0);
        chk("async_overrun", 32'(overrun), 0);
        chk("async_in_ready", 32'(in_ready), 0);
        chk("f2_queue_empty", 32'(q_addr.size()), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Frame 3: 30 accepts, 5-cycle enable pause, then random gaps
        do_start();
        for (int i = 0; i < 30; i++) accept_one(32'(1000 + i));
        settle();
        chk("pre_pause_overrun", 32'(overrun), 0);
        snap = wr_cnt;
        enable = 1'b0;
        in_data = DW'(1030);
        repeat (5) settle();
        chk("pause_no_write", wr_cnt, snap);
        chk("pause_overrun", 32'(overrun), 1);
        chk("pause_row", 32'(row), 1);
        chk("pause_col", 32'(col), 6);
        enable = 1'b1;
        snap = wr_cnt;
        n = 30;
        while (n < DEPTH) begin
            if ($urandom_range(0, 1) == 1) begin
                accept_one(1000 + n);
                n++;
            end else begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        chk("f3_done", 32'(done), 1);
        chk("f3_last_addr", 32'(wr_addr), 575);
        settle();
        chk("f3_wr_count", wr_cnt - snap, DEPTH - 30);
        chk("f3_queue_empty", 32'(q_addr.size()), 0);

        // After reset, in_valid without start must not be accepted
        reset = 1'b1;
        #3;
        reset = 1'b0;
        snap = wr_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("nostart_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        settle();
        chk("nostart_no_write", wr_cnt, snap);
        chk("nostart_done", 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
